// File: rtl/gf180mcu_osu_sc_12t_oai_filt_if.sv
// Bus bundle for the filtered OAI block: enable, OR-group/AND inputs, filtered
// outputs and the busy flag. Signal names match the original flat ports.
interface gf180mcu_osu_sc_12t_oai_filt_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned NA = 3
);
  logic          EN;
  logic [CH*NA-1:0] A;
  logic [CH-1:0] B;
  logic [CH-1:0] Y;
  logic [CH-1:0] YC;
  logic          BUSY;

  modport master (
    output EN,
    output A,
    output B,
    input  Y,
    input  YC,
    input  BUSY
  );

  modport slave (
    input  EN,
    input  A,
    input  B,
    output Y,
    output YC,
    output BUSY
  );
endinterface

// File: rtl/gf180mcu_osu_sc_12t_oai_filt.sv
// Per-channel OAI gate (~(|A_group & B)) followed by a persistence filter:
// Y only follows the raw value after DEPTH consecutive enabled differing samples.
module gf180mcu_osu_sc_12t_oai_filt #(
  parameter int unsigned CH    = 4,
  parameter int unsigned NA    = 3,
  parameter int unsigned DEPTH = 3
) (
  input  logic CLK,
  input  logic R,
  gf180mcu_osu_sc_12t_oai_filt_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_t;

  logic [CH-1:0] raw;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  logic [CH-1:0] y_q;
  logic [CH-1:0] y_d;
  logic [CH-1:0] yc_q;
  logic [CH-1:0] yc_d;
  ch_state_t     state [CH];
  logic          busy;

  always_comb begin
    raw = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      raw[c] = ~((|bus.A[c*NA +: NA]) & bus.B[c]);
    end
  end

  // Channel state is purely a view of the counter; no separate state flops.
  always_comb begin
    busy = 1'b0;
    for (int unsigned c = 0; c < CH; c++) begin
      state[c] = (cnt_q[c] != '0) ? ST_PENDING : ST_STABLE;
      busy     = busy | (state[c] == ST_PENDING);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    y_d   = y_q;
    yc_d  = '0;
    if (bus.EN) begin
      for (int unsigned c = 0; c < CH; c++) begin
        if (raw[c] == y_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          // Counter never exceeds CNT_LAST, so equality is the commit point.
          y_d[c]   = raw[c];
          yc_d[c]  = 1'b1;
          cnt_d[c] = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      y_q  <= '1;
      yc_q <= '0;
      for (int unsigned c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      y_q  <= y_d;
      yc_q <= yc_d;
      for (int unsigned c = 0; c < CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign bus.Y    = y_q;
  assign bus.YC   = yc_q;
  assign bus.BUSY = busy;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_oai_filt.sv
// Scoreboard bench: directed steps push hand-computed expectations, monitors
// pop and compare one entry after each rising edge.
module tb_gf180mcu_osu_sc_12t_oai_filt;

  logic CLK = 1'b0;
  logic R;
  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_12t_oai_filt_if #(.CH(4), .NA(3)) b1 ();
  gf180mcu_osu_sc_12t_oai_filt_if #(.CH(2), .NA(2)) b2 ();

  gf180mcu_osu_sc_12t_oai_filt #(.CH(4), .NA(3), .DEPTH(3)) dut1 (
    .CLK(CLK),
    .R  (R),
    .bus(b1)
  );

  gf180mcu_osu_sc_12t_oai_filt #(.CH(2), .NA(2), .DEPTH(1)) dut2 (
    .CLK(CLK),
    .R  (R),
    .bus(b2)
  );

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] yc;
    logic       busy;
  } exp1_t;

  typedef struct packed {
    logic [1:0] y;
    logic [1:0] yc;
    logic       busy;
  } exp2_t;

  exp1_t q1 [$];
  string n1 [$];
  exp2_t q2 [$];
  string n2 [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic s1(input string nm, input logic r, input logic en,
                    input logic [11:0] a, input logic [3:0] b,
                    input logic [3:0] ey, input logic [3:0] eyc, input logic ebusy);
    exp1_t e;
    @(negedge CLK);
    R    = r;
    b1.EN = en;
    b1.A  = a;
    b1.B  = b;
    e.y = ey; e.yc = eyc; e.busy = ebusy;
    q1.push_back(e);
    n1.push_back(nm);
  endtask

  task automatic s2(input string nm, input logic en, input logic [3:0] a,
                    input logic [1:0] b, input logic [1:0] ey, input logic [1:0] eyc);
    exp2_t e;
    @(negedge CLK);
    b2.EN = en;
    b2.A  = a;
    b2.B  = b;
    e.y = ey; e.yc = eyc; e.busy = 1'b0;
    q2.push_back(e);
    n2.push_back(nm);
  endtask

  always @(posedge CLK) begin
    exp1_t e;
    string nm;
    #1;
    if (q1.size() > 0) begin
      e  = q1.pop_front();
      nm = n1.pop_front();
      chk({nm, ".Y"},    32'(b1.Y),    32'(e.y));
      chk({nm, ".YC"},   32'(b1.YC),   32'(e.yc));
      chk({nm, ".BUSY"}, 32'(b1.BUSY), 32'(e.busy));
    end
  end

  always @(posedge CLK) begin
    exp2_t e;
    string nm;
    #1;
    if (q2.size() > 0) begin
      e  = q2.pop_front();
      nm = n2.pop_front();
      chk({nm, ".Y"},    32'(b2.Y),    32'(e.y));
      chk({nm, ".YC"},   32'(b2.YC),   32'(e.yc));
      chk({nm, ".BUSY"}, 32'(b2.BUSY), 32'(e.busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    R = 1'b1;
    b1.EN = 1'b1; b1.A = '0; b1.B = '0;
    b2.EN = 1'b1; b2.A = '0; b2.B = '0;
    #2;
    chk("rst.Y",    32'(b1.Y),    32'hF);
    chk("rst.YC",   32'(b1.YC),   32'h0);
    chk("rst.BUSY", 32'(b1.BUSY), 32'h0);
    chk("rst2.Y",   32'(b2.Y),    32'h3);

    s1("rst0", 1, 1, 12'h000, 4'h0, 4'hF, 4'h0, 0);
    s1("rst1", 1, 1, 12'h000, 4'h0, 4'hF, 4'h0, 0);
    s1("idle", 0, 1, 12'h000, 4'h0, 4'hF, 4'h0, 0);

    // channel 0 falls after three enabled edges
    s1("t1e1", 0, 1, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("t1e2", 0, 1, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("t1e3", 0, 1, 12'h001, 4'h1, 4'hE, 4'h1, 0);
    s1("t1e4", 0, 1, 12'h001, 4'h1, 4'hE, 4'h0, 0);
    s1("t1en0", 0, 0, 12'h000, 4'h0, 4'hE, 4'h0, 0);
    s1("t1r1", 0, 1, 12'h000, 4'h0, 4'hE, 4'h0, 1);
    s1("t1r2", 0, 1, 12'h000, 4'h0, 4'hE, 4'h0, 1);
    s1("t1r3", 0, 1, 12'h000, 4'h0, 4'hF, 4'h1, 0);

    // glitch aborts a pending change
    s1("g1", 0, 1, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("g2", 0, 1, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("g3", 0, 1, 12'h000, 4'h0, 4'hF, 4'h0, 0);
    s1("g4", 0, 1, 12'h000, 4'h0, 4'hF, 4'h0, 0);

    // EN pattern 1,0,0,1,1
    s1("en1", 0, 1, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("en2", 0, 0, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("en3", 0, 0, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("en4", 0, 1, 12'h001, 4'h1, 4'hF, 4'h0, 1);
    s1("en5", 0, 1, 12'h001, 4'h1, 4'hE, 4'h1, 0);
    s1("enr1", 0, 1, 12'h000, 4'h0, 4'hE, 4'h0, 1);
    s1("enr2", 0, 1, 12'h000, 4'h0, 4'hE, 4'h0, 1);
    s1("enr3", 0, 1, 12'h000, 4'h0, 4'hF, 4'h1, 0);

    // channels 1 and 3 together
    s1("m1", 0, 1, 12'h810, 4'hA, 4'hF, 4'h0, 1);
    s1("m2", 0, 1, 12'h810, 4'hA, 4'hF, 4'h0, 1);
    s1("m3", 0, 1, 12'h810, 4'hA, 4'h5, 4'hA, 0);
    s1("m4", 0, 1, 12'h810, 4'hA, 4'h5, 4'h0, 0);
    s1("mr1", 0, 1, 12'h000, 4'h0, 4'h5, 4'h0, 1);
    s1("mr2", 0, 1, 12'h000, 4'h0, 4'h5, 4'h0, 1);
    s1("mr3", 0, 1, 12'h000, 4'h0, 4'hF, 4'hA, 0);

    // async reset while channel 2 is pending
    s1("p1", 0, 1, 12'h040, 4'h4, 4'hF, 4'h0, 1);
    s1("p2", 0, 1, 12'h040, 4'h4, 4'hF, 4'h0, 1);
    @(posedge CLK);
    #3;
    R = 1'b1;
    #1;
    chk("arst.Y",    32'(b1.Y),    32'hF);
    chk("arst.YC",   32'(b1.YC),   32'h0);
    chk("arst.BUSY", 32'(b1.BUSY), 32'h0);
    s1("prst", 1, 1, 12'h040, 4'h4, 4'hF, 4'h0, 0);
    s1("f1", 0, 1, 12'h040, 4'h4, 4'hF, 4'h0, 1);
    s1("f2", 0, 1, 12'h040, 4'h4, 4'hF, 4'h0, 1);
    s1("f3", 0, 1, 12'h040, 4'h4, 4'hB, 4'h4, 0);
    s1("fr1", 0, 1, 12'h000, 4'h0, 4'hB, 4'h0, 1);
    s1("fr2", 0, 1, 12'h000, 4'h0, 4'hB, 4'h0, 1);
    s1("fr3", 0, 1, 12'h000, 4'h0, 4'hF, 4'h4, 0);

    // DEPTH=1, NA=2 build: Y[0] follows ~B[0] one cycle late
    s2("d1", 1, 4'h3, 2'b01, 2'b10, 2'b01);
    s2("d2", 1, 4'h3, 2'b00, 2'b11, 2'b01);
    s2("d3", 1, 4'h3, 2'b01, 2'b10, 2'b01);
    s2("d4", 1, 4'h3, 2'b00, 2'b11, 2'b01);
    s2("d5", 1, 4'h3, 2'b01, 2'b10, 2'b01);
    s2("d6", 1, 4'h3, 2'b00, 2'b11, 2'b01);
    s2("d7", 0, 4'h3, 2'b01, 2'b11, 2'b00);
    s2("d8", 1, 4'h3, 2'b00, 2'b11, 2'b00);

    @(negedge CLK);
    @(negedge CLK);
    chk("drain", 32'(q1.size() + q2.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_12t_oai_filt.md
GF180MCU_OSU_SC_12T_OAI_FILT -- requirements
Module: gf180mcu_osu_sc_12T_oai_filt

Interface
REQ-001 Parameter CH, default 4: number of independent channels, legal range 1..16.
REQ-002 Parameter NA, default 3: OR-group width per channel, legal range 2..4.
REQ-003 Parameter DEPTH, default 3: consecutive enabled cycles a new value must persist before Y changes, legal range 1..15.
REQ-004 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port R, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port EN, input, 1 bit: clock enable for filter evaluation.
REQ-007 Port A, input, CH*NA bits: OR-group inputs; channel c input i is bit c*NA+i.
REQ-008 Port B, input, CH bits: AND input; channel c is bit c.
REQ-009 Port Y, output, CH bits: registered, filtered OAI result per channel.
REQ-010 Port YC, output, CH bits: one-cycle pulse when the matching Y bit changes.
REQ-011 Port BUSY, output, 1 bit: high while any channel has a pending, unconfirmed change.

Function
REQ-012 Per channel c, the combinational raw value SHALL be raw[c] = ~((A[c*NA] | ... | A[c*NA+NA-1]) & B[c]).
REQ-013 Each channel SHALL hold a counter cnt[c] of width ceil(log2(DEPTH+1)) bits, plus the Y[c] register.
REQ-014 Channel state SHALL be STABLE when cnt[c]==0 and PENDING when cnt[c]!=0; no other state encoding SHALL exist.
REQ-015 On a rising edge with EN=1 and raw[c]==Y[c]: cnt[c]<=0, Y[c] held, YC[c]<=0 (a glitch aborts a pending change).
REQ-016 On a rising edge with EN=1, raw[c]!=Y[c] and cnt[c]<DEPTH-1: cnt[c]<=cnt[c]+1, Y[c] held, YC[c]<=0.
REQ-017 On a rising edge with EN=1, raw[c]!=Y[c] and cnt[c]==DEPTH-1: Y[c]<=raw[c], YC[c]<=1, cnt[c]<=0.
REQ-018 Latency SHALL be exactly DEPTH enabled edges from the first edge sampling a differing raw value to Y[c] changing; with DEPTH=1, Y is raw registered with one-cycle latency.
REQ-019 On a rising edge with EN=0: cnt and Y SHALL hold, and YC SHALL be cleared to 0; cycles with EN=0 neither count nor abort.
REQ-020 cnt[c] SHALL never exceed DEPTH-1 and SHALL never wrap.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous YC pulses.
REQ-022 BUSY SHALL be the combinational OR over all channels of (cnt[c]!=0).
REQ-023 A and B SHALL be treated as synchronous to CLK; no input synchronisers are included.

Reset
REQ-024 While R=1, regardless of CLK, the block SHALL force Y=all ones, YC=0, every cnt=0 and BUSY=0.
REQ-025 Assertion of R mid-PENDING SHALL discard the pending change with no YC pulse.
REQ-026 After R deasserts, the first rising edge SHALL evaluate normally, per REQ-015..REQ-019.

Verification
REQ-027 Parameters CH=4, NA=3, DEPTH=3, EN=1 throughout, reset, then hold A[2:0]=3'b001 and B[0]=1 (so raw[0]=0) -> Y[0] stays 1 for 2 edges, falls on the 3rd edge, YC[0]=1 for exactly that cycle, and BUSY=1 for the 2 preceding cycles.
REQ-028 Glitch: from Y[0]=1, hold raw[0]=0 for 2 edges, then raw[0]=1 for 1 edge -> Y[0] remains 1, no YC pulse, cnt[0] returns to 0, BUSY=0.
REQ-029 EN gating: hold raw[0]=0 with EN pattern 1,0,0,1,1 -> Y[0] falls on the 5th edge (3rd enabled edge) and YC[0] pulses once.
REQ-030 Multi-channel: drive raw=0 on channels 1 and 3 at the same edge -> Y becomes 4'b0101 after 3 edges, and YC=4'b1010 for one cycle.
REQ-031 Reset mid-operation: assert R asynchronously between edges after 2 pending edges on channel 2 -> Y[2]=1 and BUSY=0 immediately, with no YC pulse afterward until 3 fresh differing edges.
REQ-032 DEPTH=1 and NA=2 build: toggle B[0] each cycle with A[1:0]=2'b11 -> Y[0] equals ~B[0] delayed one cycle, and YC[0]=1 every cycle.
